pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 139 +++++++++++++
 tb/tb_pc_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: boot, sequential fetch, stalls and flushing branch redirects.
// Optional trap entry is compiled in when PC_SEQ_TRAP_EN is defined.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        IMEM_BUSYWAIT,
    input  logic        DMEM_BUSYWAIT,
    input  logic        HAZARD_STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
`ifdef PC_SEQ_TRAP_EN
    input  logic        TRAP,
`endif
    output logic [31:0] PC,
    output logic [31:0] PC_PLUS4,
    output logic        IMEM_READ,
    output logic        FLUSH
);

`ifdef PC_SEQ_TRAP_EN
    typedef enum logic [1:0] {StBoot, StRun, StRedirect, StTrapping} state_e;
`else
    typedef enum logic [1:0] {StBoot, StRun, StRedirect} state_e;
`endif

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pending_q, pending_d;
    logic        imem_read_q;
    logic [1:0]  rst_sync_q;
    logic        run_en;
    logic        memwait;
    logic        stall;
    logic        trap_req;
    logic        flush;
    logic [31:0] target_aligned;

    assign run_en         = rst_sync_q[1];
    assign memwait        = IMEM_BUSYWAIT | DMEM_BUSYWAIT;
    assign stall          = memwait | HAZARD_STALL;
    assign target_aligned = {BRANCH_TARGET[31:2], 2'b00};

`ifdef PC_SEQ_TRAP_EN
    assign trap_req = TRAP;
`else
    assign trap_req = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pending_d = pending_q;
        flush     = 1'b0;
        unique case (state_q)
            StBoot: begin
                if (run_en) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (trap_req) begin
                    if (!memwait) begin
                        flush = 1'b1;
                        pc_d  = TRAP_VECTOR;
                    end else begin
`ifdef PC_SEQ_TRAP_EN
                        state_d = StTrapping;
`endif
                    end
                end else if (BRANCH_TAKEN) begin
                    if (!memwait) begin
                        flush = 1'b1;
                        pc_d  = target_aligned;
                    end else begin
                        pending_d = target_aligned;
                        state_d   = StRedirect;
                    end
                end else if (!stall) begin
                    pc_d = PC_PLUS4;
                end
            end
            // The stalled branch is still in EX, so BRANCH_TAKEN is ignored here.
            StRedirect: begin
                if (trap_req) begin
                    if (!memwait) begin
                        flush   = 1'b1;
                        pc_d    = TRAP_VECTOR;
                        state_d = StRun;
                    end else begin
`ifdef PC_SEQ_TRAP_EN
                        state_d = StTrapping;
`endif
                    end
                end else if (!memwait) begin
                    flush   = 1'b1;
                    pc_d    = pending_q;
                    state_d = StRun;
                end
            end
`ifdef PC_SEQ_TRAP_EN
            StTrapping: begin
                if (!memwait) begin
                    flush   = 1'b1;
                    pc_d    = TRAP_VECTOR;
                    state_d = StRun;
                end
            end
`endif
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            rst_sync_q  <= 2'b00;
            state_q     <= StBoot;
            pc_q        <= RESET_VECTOR;
            pending_q   <= 32'h0000_0000;
            imem_read_q <= 1'b0;
        end else begin
            rst_sync_q  <= {rst_sync_q[0], 1'b1};
            state_q     <= state_d;
            pc_q        <= pc_d;
            pending_q   <= pending_d;
            imem_read_q <= (state_d != StBoot);
        end
    end

    assign PC        = pc_q;
    assign PC_PLUS4  = pc_q + 32'd4;
    assign IMEM_READ = imem_read_q;
    assign FLUSH     = flush;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (trap case built only with PC_SEQ_TRAP_EN).
module tb_pc_sequencer;

    logic        CLOCK;
    logic        RESET;
    logic        IMEM_BUSYWAIT;
    logic        DMEM_BUSYWAIT;
    logic        HAZARD_STALL;
    logic        BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
`ifdef PC_SEQ_TRAP_EN
    logic        TRAP;
`endif
    logic [31:0] PC;
    logic [31:0] PC_PLUS4;
    logic        IMEM_READ;
    logic        FLUSH;

    int n_checks = 0;
    int n_fail   = 0;

    pc_sequencer dut (
        .CLOCK         (CLOCK),
        .RESET         (RESET),
        .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
        .DMEM_BUSYWAIT (DMEM_BUSYWAIT),
        .HAZARD_STALL  (HAZARD_STALL),
        .BRANCH_TAKEN  (BRANCH_TAKEN),
        .BRANCH_TARGET (BRANCH_TARGET),
`ifdef PC_SEQ_TRAP_EN
        .TRAP          (TRAP),
`endif
        .PC            (PC),
        .PC_PLUS4      (PC_PLUS4),
        .IMEM_READ     (IMEM_READ),
        .FLUSH         (FLUSH)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 2 time units later.
    task automatic tick;
        @(posedge CLOCK);
        #2;
    endtask

    initial begin
        RESET         = 1'b0;
        IMEM_BUSYWAIT = 1'b0;
        DMEM_BUSYWAIT = 1'b0;
        HAZARD_STALL  = 1'b0;
        BRANCH_TAKEN  = 1'b0;
        BRANCH_TARGET = 32'h0;
`ifdef PC_SEQ_TRAP_EN
        TRAP          = 1'b0;
`endif
        tick();
        tick();
        check_eq("rst_pc", PC, 32'h0);
        check_eq("rst_pc4", PC_PLUS4, 32'h4);
        check_eq("rst_imem_read", {31'b0, IMEM_READ}, 32'h0);
        check_eq("rst_flush", {31'b0, FLUSH}, 32'h0);

        // Release reset; two synchroniser edges keep BOOT, third enters RUN.
        RESET = 1'b1;
        tick();
        check_eq("sync1_imem_read", {31'b0, IMEM_READ}, 32'h0);
        tick();
        check_eq("sync2_imem_read", {31'b0, IMEM_READ}, 32'h0);
        check_eq("sync2_pc", PC, 32'h0);
        tick();
        check_eq("run_imem_read", {31'b0, IMEM_READ}, 32'h1);
        check_eq("run_pc0", PC, 32'h0);
        tick();
        check_eq("run_pc4", PC, 32'h4);
        tick();
        check_eq("run_pc8", PC, 32'h8);
        tick();
        tick();
        check_eq("run_pc10", PC, 32'h10);

        // Hazard stall for two cycles.
        HAZARD_STALL = 1'b1;
        #1 check_eq("stall_flush", {31'b0, FLUSH}, 32'h0);
        tick();
        check_eq("stall_pc_a", PC, 32'h10);
        check_eq("stall_flush_a", {31'b0, FLUSH}, 32'h0);
        tick();
        check_eq("stall_pc_b", PC, 32'h10);
        HAZARD_STALL = 1'b0;
        tick();
        check_eq("stall_release_pc", PC, 32'h14);
        tick();
        tick();
        tick();
        check_eq("pc20", PC, 32'h20);

        // Taken branch without memory wait; target low bits are dropped.
        BRANCH_TAKEN  = 1'b1;
        BRANCH_TARGET = 32'h103;
        #1 check_eq("br_flush", {31'b0, FLUSH}, 32'h1);
        tick();
        BRANCH_TAKEN = 1'b0;
        #1 check_eq("br_pc", PC, 32'h100);
        check_eq("br_flush_after", {31'b0, FLUSH}, 32'h0);

        // Branch under data-memory wait; later target must not replace the pending one.
        BRANCH_TAKEN  = 1'b1;
        BRANCH_TARGET = 32'h200;
        DMEM_BUSYWAIT = 1'b1;
        #1 check_eq("rd_flush_c1", {31'b0, FLUSH}, 32'h0);
        tick();
        BRANCH_TARGET = 32'h300;
        #1 check_eq("rd_pc_c2", PC, 32'h100);
        check_eq("rd_flush_c2", {31'b0, FLUSH}, 32'h0);
        tick();
        check_eq("rd_pc_c3", PC, 32'h100);
        check_eq("rd_flush_c3", {31'b0, FLUSH}, 32'h0);
        DMEM_BUSYWAIT = 1'b0;
        #1 check_eq("rd_commit_flush", {31'b0, FLUSH}, 32'h1);
        tick();
        BRANCH_TAKEN = 1'b0;
        #1 check_eq("rd_pc_target", PC, 32'h200);
        check_eq("rd_flush_done", {31'b0, FLUSH}, 32'h0);

        // Branch overrides a hazard stall.
        HAZARD_STALL  = 1'b1;
        BRANCH_TAKEN  = 1'b1;
        BRANCH_TARGET = 32'h80;
        #1 check_eq("hz_br_flush", {31'b0, FLUSH}, 32'h1);
        tick();
        HAZARD_STALL = 1'b0;
        BRANCH_TAKEN = 1'b0;
        #1 check_eq("hz_br_pc", PC, 32'h80);

        // Wraparound at the top of the address space.
        BRANCH_TAKEN  = 1'b1;
        BRANCH_TARGET = 32'hFFFF_FFFF;
        tick();
        BRANCH_TAKEN = 1'b0;
        #1 check_eq("wrap_pc", PC, 32'hFFFF_FFFC);
        check_eq("wrap_pc4", PC_PLUS4, 32'h0);
        tick();
        check_eq("wrap_pc_next", PC, 32'h0);
        tick();
        check_eq("wrap_pc_next2", PC, 32'h4);

        // Reset in REDIRECT drops the pending target.
        BRANCH_TAKEN  = 1'b1;
        BRANCH_TARGET = 32'h400;
        IMEM_BUSYWAIT = 1'b1;
        tick();
        check_eq("rdr_pc_hold", PC, 32'h4);
        RESET = 1'b0;
        #1 check_eq("rdr_rst_pc", PC, 32'h0);
        check_eq("rdr_rst_imem_read", {31'b0, IMEM_READ}, 32'h0);
        check_eq("rdr_rst_flush", {31'b0, FLUSH}, 32'h0);
        BRANCH_TAKEN  = 1'b0;
        IMEM_BUSYWAIT = 1'b0;
        tick();
        RESET = 1'b1;
        tick();
        tick();
        check_eq("rerun_boot_imem", {31'b0, IMEM_READ}, 32'h0);
        tick();
        check_eq("rerun_imem_read", {31'b0, IMEM_READ}, 32'h1);
        check_eq("rerun_pc", PC, 32'h0);
        check_eq("rerun_flush", {31'b0, FLUSH}, 32'h0);
        tick();
        check_eq("rerun_pc4", PC, 32'h4);

`ifdef PC_SEQ_TRAP_EN
        // Trap wins over a simultaneous branch.
        TRAP          = 1'b1;
        BRANCH_TAKEN  = 1'b1;
        BRANCH_TARGET = 32'h500;
        #1 check_eq("trap_flush", {31'b0, FLUSH}, 32'h1);
        tick();
        TRAP         = 1'b0;
        BRANCH_TAKEN = 1'b0;
        #1 check_eq("trap_pc", PC, 32'h100);
        check_eq("trap_flush_after", {31'b0, FLUSH}, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
